// File: rtl/alu_bus_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_bus_sequencer_if
// Description : Request, result and tristate-enable signals of the ALU result
//               bus sequencer, bundled with requester/sequencer views.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_bus_sequencer_if #(
    parameter int WIDTH  = 32,
    parameter int NUNITS = 8,
    parameter int SEL_W  = 3
);
    logic              op_valid;
    logic              op_ready;
    logic [SEL_W-1:0]  op_sel;
    logic [NUNITS-1:0] bus_en_n;
    logic [WIDTH-1:0]  bus_in;
    logic              res_valid;
    logic              res_ready;
    logic [WIDTH-1:0]  result;
    logic              zero;
    logic              neg;
    logic              sel_err;

    // Requester side: issues ops, provides the resolved bus, consumes results
    modport master (
        output op_valid, op_sel, bus_in, res_ready,
        input  op_ready, bus_en_n, res_valid, result, zero, neg, sel_err
    );

    // Sequencer side
    modport slave (
        input  op_valid, op_sel, bus_in, res_ready,
        output op_ready, bus_en_n, res_valid, result, zero, neg, sel_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_bus_sequencer
// Description : Grants one ALU tristate driver the shared result bus for a
//               fixed settle window, captures the bus and holds the result.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_bus_sequencer #(
    parameter int WIDTH  = 32,
    parameter int NUNITS = 8,
    parameter int SEL_W  = 3,
    parameter int SETTLE = 1
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    alu_bus_sequencer_if.slave bus
);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_DRIVE = 2'd1;
    localparam logic [1:0] c_HOLD  = 2'd2;

    localparam int                 c_CNT_W  = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_SETTLE = c_CNT_W'(SETTLE);
    localparam logic [31:0]        c_NUNITS = NUNITS;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_neg;
    logic               r_sel_err;

    logic               w_sel_ok;
    logic               w_accept;
    logic               w_capture;
    logic               w_op_ready;
    logic               w_res_valid;
    logic [NUNITS-1:0]  w_en_n;

    assign w_sel_ok  = {{(32-SEL_W){1'b0}}, bus.op_sel} < c_NUNITS;
    assign w_accept  = (r_state == c_IDLE) && bus.op_valid;
    assign w_capture = (r_state == c_DRIVE) && (r_cnt == '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.op_valid) begin
                    w_state_nxt = w_sel_ok ? c_DRIVE : c_HOLD;
                end
            end
            c_DRIVE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_HOLD;
                end
            end
            c_HOLD: begin
                if (bus.res_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: only DRIVE ever pulls an enable low, and only one
    // ------------------------------------------------------------------
    always_comb begin
        w_op_ready  = reset_n && (r_state == c_IDLE);
        w_res_valid = (r_state == c_HOLD);
        w_en_n      = '1;
        for (int i = 0; i < NUNITS; i++) begin
            if ((r_state == c_DRIVE) && (r_sel == SEL_W'(i))) begin
                w_en_n[i] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Select/counter and result datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sel     <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_neg     <= 1'b0;
            r_sel_err <= 1'b0;
        end else if (w_accept) begin
            r_sel <= bus.op_sel;
            r_cnt <= c_SETTLE;
            // An out-of-range unit never drives; report a zero result instead
            if (!w_sel_ok) begin
                r_result  <= '0;
                r_zero    <= 1'b1;
                r_neg     <= 1'b0;
                r_sel_err <= 1'b1;
            end
        end else if (w_capture) begin
            r_result  <= bus.bus_in;
            r_zero    <= (bus.bus_in == '0);
            r_neg     <= bus.bus_in[WIDTH-1];
            r_sel_err <= 1'b0;
        end else if (r_state == c_DRIVE) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign bus.op_ready  = w_op_ready;
    assign bus.res_valid = w_res_valid;
    assign bus.bus_en_n  = w_en_n;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.neg       = r_neg;
    assign bus.sel_err   = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_bus_sequencer
// Description : Self-checking bench for alu_bus_sequencer (8-unit and 6-unit).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_bus_sequencer;
    localparam int c_SETTLE = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [31:0] unit_val [8];

    always #5 clk = ~clk;

    alu_bus_sequencer_if #(.WIDTH(32), .NUNITS(8), .SEL_W(3)) bus8 ();
    alu_bus_sequencer_if #(.WIDTH(32), .NUNITS(6), .SEL_W(3)) bus6 ();

    alu_bus_sequencer #(.WIDTH(32), .NUNITS(8), .SEL_W(3), .SETTLE(c_SETTLE)) dut8 (
        .clk(clk), .reset_n(reset_n), .bus(bus8.slave));
    alu_bus_sequencer #(.WIDTH(32), .NUNITS(6), .SEL_W(3), .SETTLE(c_SETTLE)) dut6 (
        .clk(clk), .reset_n(reset_n), .bus(bus6.slave));

    // Shared bus model: the enabled unit drives its value, otherwise a float pattern
    always_comb begin
        bus8.bus_in = 32'hDEAD_BEEF;
        for (int i = 0; i < 8; i++) if (!bus8.bus_en_n[i]) bus8.bus_in = unit_val[i];
    end
    always_comb begin
        bus6.bus_in = 32'hDEAD_BEEF;
        for (int i = 0; i < 6; i++) if (!bus6.bus_en_n[i]) bus6.bus_in = unit_val[i];
    end

    // Bus safety: never two drivers, never a driver while a result is held
    always @(negedge clk) begin
        if (reset_n) begin
            n_checks++;
            if ($countones(~bus8.bus_en_n) > 1 || $countones(~bus6.bus_en_n) > 1 ||
                (bus8.res_valid === 1'b1 && bus8.bus_en_n !== 8'hFF) ||
                (bus6.res_valid === 1'b1 && bus6.bus_en_n !== 6'h3F)) begin
                n_fail++;
                $display("FAIL bus_safety: got en8=%h en6=%h rv8=%b rv6=%b, required at most one low and none while valid",
                         bus8.bus_en_n, bus6.bus_en_n, bus8.res_valid, bus6.res_valid);
            end
        end
    end

    task automatic run_op(input int s, input logic [31:0] v, input int stall);
        logic [7:0] exp_en;
        exp_en = ~(8'h01 << s);
        unit_val[s] = v;
        @(negedge clk);
        n_checks++;
        if (bus8.op_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL op_ready_idle: got %b required 1", bus8.op_ready);
        end
        bus8.op_sel = 3'(s);
        bus8.op_valid = 1'b1;
        @(posedge clk); #1;
        // Post-acceptance changes must be ignored
        bus8.op_valid = 1'($urandom_range(0, 1));
        bus8.op_sel = 3'($urandom);
        for (int c = 0; c <= c_SETTLE; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus8.bus_en_n !== exp_en || bus8.res_valid !== 1'b0 || bus8.op_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL drive_window[%0d]: got en=%h rv=%b rdy=%b required en=%h rv=0 rdy=0",
                         c, bus8.bus_en_n, bus8.res_valid, bus8.op_ready, exp_en);
            end
        end
        bus8.op_valid = 1'b0;
        for (int c = 0; c <= stall; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus8.res_valid !== 1'b1 || bus8.result !== v || bus8.zero !== (v == 32'h0) ||
                bus8.neg !== v[31] || bus8.sel_err !== 1'b0 || bus8.bus_en_n !== 8'hFF ||
                bus8.op_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: got rv=%b res=%h z=%b n=%b e=%b en=%h rdy=%b required rv=1 res=%h z=%b n=%b e=0 en=ff rdy=0",
                         c, bus8.res_valid, bus8.result, bus8.zero, bus8.neg, bus8.sel_err,
                         bus8.bus_en_n, bus8.op_ready, v, (v == 32'h0), v[31]);
            end
        end
        bus8.res_ready = 1'b1;
        @(posedge clk); #1;
        bus8.res_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus8.bus_en_n !== 8'hFF || bus8.res_valid !== 1'b0 || bus8.result !== 32'h0 ||
            bus8.zero !== 1'b0 || bus8.neg !== 1'b0 || bus8.sel_err !== 1'b0 || bus8.op_ready !== 1'b0 ||
            bus6.bus_en_n !== 6'h3F || bus6.res_valid !== 1'b0 || bus6.sel_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got en=%h rv=%b res=%h z=%b n=%b e=%b rdy=%b en6=%h required en=ff rv=0 res=0 flags=0 rdy=0",
                     bus8.bus_en_n, bus8.res_valid, bus8.result, bus8.zero, bus8.neg,
                     bus8.sel_err, bus8.op_ready, bus6.bus_en_n);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus8.op_ready !== 1'b1 || bus6.op_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b/%b required 1/1", bus8.op_ready, bus6.op_ready);
        end
    endtask

    task automatic test_basic_read;
        run_op(3, 32'h0000_0008, 0);
    endtask

    task automatic test_walking_bit;
        for (int k = 0; k < 8; k++) run_op(k, 32'h1 << k, 0);
        run_op(0, 32'h8000_0000, 0);
    endtask

    task automatic test_zero_flag;
        run_op(int'($urandom_range(0, 7)), 32'h0, 0);
    endtask

    task automatic test_backpressure;
        run_op(6, $urandom | 32'h1, 10);
        run_op(1, $urandom, 0);
    endtask

    task automatic test_back_to_back;
        for (int n = 0; n < 16; n++) begin
            logic [31:0] v;
            case ($urandom_range(0, 3))
                0:       v = 32'h0;
                1:       v = $urandom | 32'h8000_0000;
                default: v = $urandom;
            endcase
            run_op(int'($urandom_range(0, 7)), v, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_mid_drive;
        unit_val[5] = $urandom | 32'h1;
        @(negedge clk);
        bus8.op_sel = 3'd5;
        bus8.op_valid = 1'b1;
        @(posedge clk); #1;
        bus8.op_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus8.bus_en_n !== 8'hDF) begin
            n_fail++;
            $display("FAIL mid_drive_en: got %h required df", bus8.bus_en_n);
        end
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus8.bus_en_n !== 8'hFF || bus8.res_valid !== 1'b0 || bus8.result !== 32'h0 ||
            bus8.op_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_drive_reset: got en=%h rv=%b res=%h rdy=%b required en=ff rv=0 res=0 rdy=0",
                     bus8.bus_en_n, bus8.res_valid, bus8.result, bus8.op_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus8.op_ready !== 1'b1 || bus8.bus_en_n !== 8'hFF || bus8.res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got rdy=%b en=%h rv=%b required rdy=1 en=ff rv=0",
                     bus8.op_ready, bus8.bus_en_n, bus8.res_valid);
        end
    endtask

    task automatic test_illegal_select;
        int sels [2] = '{7, 6};
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            bus6.op_sel = 3'(sels[n]);
            bus6.op_valid = 1'b1;
            @(posedge clk); #1;
            bus6.op_valid = 1'b0;
            @(negedge clk);
            n_checks++;
            if (bus6.res_valid !== 1'b1 || bus6.result !== 32'h0 || bus6.zero !== 1'b1 ||
                bus6.neg !== 1'b0 || bus6.sel_err !== 1'b1 || bus6.bus_en_n !== 6'h3F) begin
                n_fail++;
                $display("FAIL illegal_sel_%0d: got rv=%b res=%h z=%b n=%b e=%b en=%h required rv=1 res=0 z=1 n=0 e=1 en=3f",
                         sels[n], bus6.res_valid, bus6.result, bus6.zero, bus6.neg, bus6.sel_err, bus6.bus_en_n);
            end
            bus6.res_ready = 1'b1;
            @(posedge clk); #1;
            bus6.res_ready = 1'b0;
        end
        // A legal op afterwards clears sel_err and reads the highest unit
        unit_val[5] = $urandom;
        @(negedge clk);
        bus6.op_sel = 3'd5;
        bus6.op_valid = 1'b1;
        @(posedge clk); #1;
        bus6.op_valid = 1'b0;
        for (int c = 0; c <= c_SETTLE; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus6.bus_en_n !== 6'h1F) begin
                n_fail++;
                $display("FAIL legal6_drive[%0d]: got %h required 1f", c, bus6.bus_en_n);
            end
        end
        @(negedge clk);
        n_checks++;
        if (bus6.res_valid !== 1'b1 || bus6.result !== unit_val[5] || bus6.sel_err !== 1'b0 ||
            bus6.zero !== (unit_val[5] == 32'h0) || bus6.neg !== unit_val[5][31]) begin
            n_fail++;
            $display("FAIL legal6_result: got rv=%b res=%h e=%b required rv=1 res=%h e=0",
                     bus6.res_valid, bus6.result, bus6.sel_err, unit_val[5]);
        end
        bus6.res_ready = 1'b1;
        @(posedge clk); #1;
        bus6.res_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) unit_val[i] = $urandom;
        bus8.op_valid = 1'b0; bus8.op_sel = '0; bus8.res_ready = 1'b0;
        bus6.op_valid = 1'b0; bus6.op_sel = '0; bus6.res_ready = 1'b0;
        test_reset();
        test_basic_read();
        test_walking_bit();
        test_zero_flag();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_drive();
        test_illegal_select();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
